uart_prog_loader: RTL
=====================

Name: uart_prog_loader

Overview:
- Boot-time program loader for the MCU.
- Assembles big-endian 16-bit words from UART receive bytes and writes them to instruction memory starting at LOAD_BASE.
- Detects the end-of-program word and holds the CPU in reset until loading completes.
- Owns the memory bus while loading, then releases it to the CPU. Replaces the ad hoc receive/phase logic in the MCU top.

Parameters:
- ADDR_W, 10, memory byte-address width.
- LOAD_BASE, 'h300, byte address of the first loaded word.
- END_WORD, 16'h7fff, terminator word; it is never written to memory.
- CLOCK_HZ, 27_000_000, clk frequency.
- TIMEOUT_MS, 10, inter-byte timeout used while waiting for a low byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rx_prog  in  1  sampled during rst. 1: load a program. 0: go straight to DONE.
- reload  in  1  single-cycle pulse. In DONE or ERR, restarts loading.
- rx_valid  in  1  single-cycle strobe; a UART byte is available.
- rx_data  in  8  received byte, valid with rx_valid.
- mem_addr  out  ADDR_W  write address while loading.
- mem_wr  out  1  single-cycle memory write strobe.
- mem_wdata  out  16  word to write.
- bus_own  out  1  1 while the loader owns the memory bus; the top muxes addr/data/wr on this.
- cpu_rst  out  1  hold CPU in reset.
- done  out  1  program loaded; CPU may run.
- err  out  1  address overflow occurred.
- word_cnt  out  ADDR_W  number of words written since the last start.

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (rst). All state changes happen on posedge clk.
- Reset values:
  - state = rx_prog ? WAIT_HI : DONE
  - mem_addr = LOAD_BASE; mem_wr = 0; mem_wdata = 0; word_cnt = 0; err = 0
  - cpu_rst = bus_own = rx_prog; done = ~rx_prog; timeout counter = 0
- States: WAIT_HI, WAIT_LO, WRITE, DONE, ERR.
- WAIT_HI:
  - On rx_valid: hi_byte <= rx_data, clear timeout counter, go to WAIT_LO.
- WAIT_LO:
  - On rx_valid: word = {hi_byte, rx_data}.
    - If word == END_WORD: go to DONE, with no write.
    - Otherwise: mem_wdata <= word, go to WRITE.
  - Without rx_valid: the timeout counter increments.
  - When the counter reaches CLOCK_HZ/1000*TIMEOUT_MS-1: discard hi_byte, go to WAIT_HI. This resynchronises byte phase.
- WRITE (exactly one cycle):
  - mem_wr = 1 with mem_addr and mem_wdata stable.
  - Next cycle: mem_addr += 2, word_cnt += 1.
  - If the written address was 2^ADDR_W-2: go to ERR with err <= 1. Otherwise go to WAIT_HI.
  - An rx_valid arriving in WRITE is taken as the next hi_byte and goes directly to WAIT_LO. No byte is lost.
- DONE:
  - cpu_rst = 0, bus_own = 0, done = 1. rx bytes are ignored.
  - reload: mem_addr <= LOAD_BASE, word_cnt <= 0, go to WAIT_HI.
- ERR:
  - cpu_rst = 1, bus_own = 1, err = 1, mem_wr = 0. Bytes are ignored.
  - reload clears err and restarts as from DONE.
- Output decoding: cpu_rst, bus_own and done are registered decodes of the state, so they change in the cycle after the state transition.
- mem_wr is high only in WRITE.
- Terminator detection is word-aligned only. A byte pair 7f ff that straddles two words does not terminate.
- Address arithmetic is modulo 2^ADDR_W. Wrap is never allowed to happen because the ERR transition catches it first.
- Reset mid-load: all progress is lost, err clears, and rx_prog is re-sampled.

Test Plan:
1. rst with rx_prog=1. Send bytes 12 34 AB CD 7F FF → writes of 'h1234 @'h300 and 'hABCD @'h302, one mem_wr pulse each. Then done=1, cpu_rst=0, bus_own=0, word_cnt=2.
2. rst with rx_prog=0 → done=1 and cpu_rst=0 from the first cycle after reset. rx bytes 7F FF produce no mem_wr.
3. Send byte 55, idle longer than the timeout, then send 7F FF → no write. Terminates with done=1, word_cnt=0. Confirms the stale hi byte was discarded.
4. Send 00 7F FF 00 then 7F FF → writes 'h007F @'h300 and 'hFF00 @'h302, then done. Confirms no misaligned terminator.
5. With LOAD_BASE='h3FC and ADDR_W=10, send 3 non-terminator words → writes @'h3FC and 'h3FE, then err=1 and cpu_rst=1. The third word is not written. A reload pulse clears err and mem_addr returns to 'h3FC.
6. Assert rx_valid in the WRITE cycle, and assert rst in the middle of WAIT_LO → the byte is captured as hi with no loss. After rst, state is WAIT_HI, mem_addr='h300, word_cnt=0.

Source files
------------

// File: rtl/uart_prog_loader_if.sv
// Receive-byte stream and instruction-memory write bus shared between the
// program loader (master) and the surrounding MCU top (slave).
interface uart_prog_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [15:0]       mem_wdata;
  logic              bus_own;

  modport master (
    input  rx_valid, rx_data,
    output mem_addr, mem_wr, mem_wdata, bus_own
  );

  modport slave (
    output rx_valid, rx_data,
    input  mem_addr, mem_wr, mem_wdata, bus_own
  );
endinterface

// File: rtl/uart_prog_loader.sv
// Boot-time loader: packs big-endian UART byte pairs into 16-bit words, writes
// them to instruction memory from LOAD_BASE and holds the CPU in reset until done.
module uart_prog_loader #(
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] LOAD_BASE  = 'h300,
  parameter logic [15:0]       END_WORD   = 16'h7fff,
  parameter int unsigned       CLOCK_HZ   = 27_000_000,
  parameter int unsigned       TIMEOUT_MS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_prog,
  input  logic                reload,
  uart_prog_loader_if.master  bus,
  output logic                cpu_rst,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   word_cnt
);

  localparam int unsigned       TO_LIMIT  = CLOCK_HZ / 1000 * TIMEOUT_MS - 1;
  localparam int                TO_W      = (TO_LIMIT > 0) ? $clog2(TO_LIMIT + 1) : 1;
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TO_LIMIT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {{(ADDR_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    WAIT_HI,
    WAIT_LO,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t            state, state_next;
  logic [7:0]        hi_byte;
  logic [TO_W-1:0]   to_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              wr_q;
  logic              own_q;
  logic [15:0]       word;

  logic take_hi, take_word, to_inc, advance, restart;

  assign word          = {hi_byte, bus.rx_data};
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wr    = wr_q;
  assign bus.bus_own   = own_q;

  always_comb begin
    state_next = state;
    take_hi    = 1'b0;
    take_word  = 1'b0;
    to_inc     = 1'b0;
    advance    = 1'b0;
    restart    = 1'b0;
    case (state)
      WAIT_HI: begin
        if (bus.rx_valid) begin
          take_hi    = 1'b1;
          state_next = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (bus.rx_valid) begin
          if (word == END_WORD) begin
            state_next = DONE;
          end else begin
            take_word  = 1'b1;
            state_next = WRITE;
          end
        end else if (to_cnt == TO_MAX) begin
          state_next = WAIT_HI;
        end else begin
          to_inc = 1'b1;
        end
      end
      WRITE: begin
        // Overflow wins over a byte arriving in the same cycle; that byte is dropped.
        advance = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_next = ERR;
        end else if (bus.rx_valid) begin
          take_hi    = 1'b1;
          state_next = WAIT_LO;
        end else begin
          state_next = WAIT_HI;
        end
      end
      DONE, ERR: begin
        if (reload) begin
          restart    = 1'b1;
          state_next = WAIT_HI;
        end
      end
      default: state_next = WAIT_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= rx_prog ? WAIT_HI : DONE;
      hi_byte  <= '0;
      to_cnt   <= '0;
      addr_q   <= LOAD_BASE;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      word_cnt <= '0;
      err      <= 1'b0;
      cpu_rst  <= rx_prog;
      own_q    <= rx_prog;
      done     <= ~rx_prog;
    end else begin
      state <= state_next;
      if (take_hi) begin
        hi_byte <= bus.rx_data;
        to_cnt  <= '0;
      end else if (to_inc) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (take_word) begin
        wdata_q <= word;
      end
      if (restart) begin
        addr_q   <= LOAD_BASE;
        word_cnt <= '0;
      end else if (advance) begin
        addr_q   <= addr_q + ADDR_W'(2);
        word_cnt <= word_cnt + ADDR_W'(1);
      end
      // mem_wr and err track the state being entered; cpu_rst/bus_own/done lag a cycle.
      wr_q    <= (state_next == WRITE);
      err     <= (state_next == ERR);
      cpu_rst <= (state != DONE);
      own_q   <= (state != DONE);
      done    <= (state == DONE);
    end
  end

endmodule
